seg7_scan_ctrl: RTL

Time-multiplexing scan controller that shares one Vr7seg 7-segment decoder across a 4-digit common-anode display. Holds a 16-bit hex value (4 nibbles), steps through the digits with a programmable dwell and dead-time, and drives the decoder's DIG/EN inputs plus one-hot digit anodes. New values are loaded through a strobe and applied only at frame boundaries, so a frame never mixes old and new digits. Sits between the datapath producing the display value and the Vr7seg instance in the board top level.

---
 rtl/seg7_scan_pkg.sv | 27 ++
 rtl/seg7_slot_timer.sv | 40 ++++
 rtl/seg7_scan_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_pkg.sv
// Shared types and helpers for the 4-digit 7-segment scan controller.
// Holds the scan state encoding, digit geometry and the leading-zero mask.
package seg7_scan_pkg;

  localparam int NDIG  = 4;
  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_t;

  // Bit k set means digit k may light; a digit is dark only when it and
  // every digit to its left hold zero. Digit 0 always lights.
  function automatic logic [NDIG-1:0] lz_mask(input logic [NDIG*NIB_W-1:0] v);
    logic seen;
    lz_mask = '0;
    seen    = 1'b0;
    for (int k = NDIG-1; k >= 1; k--) begin
      seen       = seen | (v[k*NIB_W +: NIB_W] != '0);
      lz_mask[k] = seen;
    end
    lz_mask[0] = 1'b1;
  endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// Loadable down-counter timing one BLANK or SHOW slot of the display scan.
// tc_next predicts the terminal count after the coming edge.
module seg7_slot_timer
  import seg7_scan_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc,
  output logic         tc_next
);

  logic [W-1:0] cnt;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt;
    if (clr)
      cnt_d = '0;
    else if (load)
      cnt_d = load_val;
    else if (cnt != '0)
      cnt_d = cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else
      cnt <= cnt_d;
  end

  assign tc      = (cnt == '0);
  assign tc_next = (cnt_d == '0);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-anode display feeding one Vr7seg decoder.
// Optional feature: define LEADING_ZERO_BLANK_EN to darken leading zero digits.
module seg7_scan_ctrl
  import seg7_scan_pkg::*;
#(
  parameter int DIV       = 4,
  parameter int BLANK_CYC = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    load,
  input  logic [NDIG*NIB_W-1:0]   data,
  output logic [NIB_W-1:0]        dig,
  output logic                    seg_en,
  output logic [NDIG-1:0]         an,
  output logic                    frame
);

  localparam int MAXC = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] SHOW_LD  = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LD = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam logic BLANK_ON = (BLANK_CYC > 0);

  scan_state_t           state, state_n;
  logic [1:0]            idx, idx_n;
  logic [NDIG*NIB_W-1:0] active, active_n;
  logic [NDIG*NIB_W-1:0] pending, pending_n;
  logic                  pend_valid, pend_valid_n;
  logic                  boundary;
  logic                  t_clr, t_load, tc, tc_next;
  logic [CW-1:0]         t_val;
  logic [NIB_W-1:0]      dig_n;
  logic                  seg_en_n, frame_n;
  logic [NDIG-1:0]       an_n, vis;

  seg7_slot_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clr      (t_clr),
    .load     (t_load),
    .load_val (t_val),
    .tc       (tc),
    .tc_next  (tc_next)
  );

  // Value staging and scan sequencing; swaps only at frame edges or while idle.
  always_comb begin
    state_n      = state;
    idx_n        = idx;
    active_n     = active;
    pending_n    = pending;
    pend_valid_n = pend_valid;
    t_clr        = 1'b0;
    t_load       = 1'b0;
    t_val        = SHOW_LD;
    boundary     = (state == ST_SHOW) && (idx == 2'(NDIG-1)) && tc;

    if (load) begin
      pending_n = data;
      if (boundary) begin
        active_n     = data;
        pend_valid_n = 1'b0;
      end else begin
        pend_valid_n = 1'b1;
      end
    end else if (pend_valid && (boundary || state == ST_IDLE)) begin
      active_n     = pending;
      pend_valid_n = 1'b0;
    end

    if (!enable) begin
      state_n = ST_IDLE;
      idx_n   = '0;
      t_clr   = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          idx_n  = '0;
          t_load = 1'b1;
          if (BLANK_ON) begin
            state_n = ST_BLANK;
            t_val   = BLANK_LD;
          end else begin
            state_n = ST_SHOW;
          end
        end
        ST_BLANK: begin
          if (tc) begin
            state_n = ST_SHOW;
            t_load  = 1'b1;
          end
        end
        ST_SHOW: begin
          if (tc) begin
            idx_n  = idx + 1'b1;
            t_load = 1'b1;
            if (BLANK_ON) begin
              state_n = ST_BLANK;
              t_val   = BLANK_LD;
            end
          end
        end
        default: begin
          state_n = ST_IDLE;
          idx_n   = '0;
          t_clr   = 1'b1;
        end
      endcase
    end
  end

  // Outputs are decoded from the upcoming state so the flops line up with it.
  always_comb begin
    dig_n    = '0;
    an_n     = '0;
    seg_en_n = 1'b0;
    frame_n  = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    vis = lz_mask(active_n);
`else
    vis = '1;
`endif
    case (state_n)
      ST_BLANK: dig_n = active_n[{idx_n, 2'b00} +: NIB_W];
      ST_SHOW: begin
        dig_n   = active_n[{idx_n, 2'b00} +: NIB_W];
        frame_n = (idx_n == 2'(NDIG-1)) && tc_next;
        if (vis[idx_n]) begin
          an_n     = NDIG'(1) << idx_n;
          seg_en_n = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      active     <= '0;
      pending    <= '0;
      pend_valid <= 1'b0;
      dig        <= '0;
      an         <= '0;
      seg_en     <= 1'b0;
      frame      <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      active     <= active_n;
      pending    <= pending_n;
      pend_valid <= pend_valid_n;
      dig        <= dig_n;
      an         <= an_n;
      seg_en     <= seg_en_n;
      frame      <= frame_n;
    end
  end

endmodule
